// File: rtl/sdram_responder_pkg.sv
// Shared definitions for the SDRAM device responder: command encodings,
// error codes, valid CAS latencies and the LOAD MODE validity check.
package sdram_pkg;

  typedef enum logic [2:0] {
    CMD_LMR       = 3'b000,
    CMD_REFRESH   = 3'b001,
    CMD_PRECHARGE = 3'b010,
    CMD_ACTIVE    = 3'b011,
    CMD_WRITE     = 3'b100,
    CMD_READ      = 3'b101,
    CMD_BST       = 3'b110,
    CMD_NOP       = 3'b111
  } cmd_e;

  localparam logic [3:0] ERR_NONE        = 4'd0;
  localparam logic [3:0] ERR_CLOSED_BANK = 4'd1;
  localparam logic [3:0] ERR_BANK_OPEN   = 4'd2;
  localparam logic [3:0] ERR_REF_OPEN    = 4'd3;
  localparam logic [3:0] ERR_NOT_READY   = 4'd4;
  localparam logic [3:0] ERR_BAD_MODE    = 4'd5;
  localparam logic [3:0] ERR_TRCD        = 4'd6;
  localparam logic [3:0] ERR_TRP         = 4'd7;
  localparam logic [3:0] ERR_TRFC        = 4'd8;
  localparam logic [3:0] ERR_WR_COLLIDE  = 4'd9;

  localparam logic [2:0] CL_2 = 3'd2;
  localparam logic [2:0] CL_3 = 3'd3;

  // Only CL2/CL3 with burst length 1 are supported.
  function automatic logic mode_valid(input logic [12:0] a);
    return ((a[6:4] == CL_2) || (a[6:4] == CL_3)) && (a[2:0] == 3'b000);
  endfunction

endpackage

// File: rtl/sdram_responder_if.sv
// SDRAM command/data bus between a controller (master) and the device
// responder (slave), plus the responder's status outputs.
interface sdram_responder_if;
  logic        SDRAM_CKE;
  logic        SDRAM_CS;
  logic        SDRAM_RAS;
  logic        SDRAM_CAS;
  logic        SDRAM_WE;
  logic [1:0]  SDRAM_BA;
  logic [12:0] SDRAM_A;
  logic        SDRAM_DQML;
  logic        SDRAM_DQMU;
  logic [15:0] D_IN;
  logic [15:0] D_OUT;
  logic        D_OE;
  logic        READY;
  logic [3:0]  BANK_OPEN;
  logic        ERR;
  logic [3:0]  ERR_CODE;
  logic [15:0] REFRESH_COUNT;

  modport master (
    output SDRAM_CKE, SDRAM_CS, SDRAM_RAS, SDRAM_CAS, SDRAM_WE, SDRAM_BA,
           SDRAM_A, SDRAM_DQML, SDRAM_DQMU, D_IN,
    input  D_OUT, D_OE, READY, BANK_OPEN, ERR, ERR_CODE, REFRESH_COUNT
  );

  modport slave (
    input  SDRAM_CKE, SDRAM_CS, SDRAM_RAS, SDRAM_CAS, SDRAM_WE, SDRAM_BA,
           SDRAM_A, SDRAM_DQML, SDRAM_DQMU, D_IN,
    output D_OUT, D_OE, READY, BANK_OPEN, ERR, ERR_CODE, REFRESH_COUNT
  );
endinterface

// File: rtl/sdram_responder_cas_pipe.sv
// Read-data latency pipe: 3-deep valid/data shift register whose CL-selected
// tap feeds a registered D_OUT/D_OE pair.
module sdram_cas_pipe (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cl3,
  input  logic        i_push,
  input  logic [15:0] i_data,
  output logic [15:0] o_data,
  output logic        o_valid,
  output logic        o_busy
);
  logic [2:0]  r_vld;
  logic [15:0] r_dat [3];
  logic [15:0] r_out;
  logic        r_oe;
  logic        w_tap_vld;
  logic [15:0] w_tap_dat;

  // Stage k is visible k edges after the READ; the output register adds one.
  always_comb begin
    w_tap_vld = r_vld[1];
    w_tap_dat = r_dat[1];
    if (i_cl3) begin
      w_tap_vld = r_vld[2];
      w_tap_dat = r_dat[2];
    end else begin
      w_tap_vld = r_vld[1];
      w_tap_dat = r_dat[1];
    end
  end

  // Shift register and output stage; reset flushes pending reads.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld    <= 3'b000;
      r_dat[0] <= 16'h0000;
      r_dat[1] <= 16'h0000;
      r_dat[2] <= 16'h0000;
      r_out    <= 16'h0000;
      r_oe     <= 1'b0;
    end else begin
      r_vld    <= {r_vld[1:0], i_push};
      r_dat[0] <= i_data;
      r_dat[1] <= r_dat[0];
      r_dat[2] <= r_dat[1];
      r_oe     <= w_tap_vld;
      r_out    <= w_tap_vld ? w_tap_dat : 16'h0000;
    end
  end

  assign o_data  = r_out;
  assign o_valid = r_oe;
  // A read is pending while it sits ahead of the selected tap.
  assign o_busy  = r_vld[0] | (i_cl3 & r_vld[1]);
endmodule

// File: rtl/sdram_responder.sv
// SDR SDRAM device responder: command decode, bank/row tracking, byte-masked
// backing array and protocol checking. SDRAM_RESPONDER_TIMING_CHECK_EN adds tRCD/tRP/tRFC checks.
module sdram_responder
  import sdram_pkg::*;
#(
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 4,
  parameter int T_RCD    = 2,
  parameter int T_RP     = 2,
  parameter int T_RFC    = 4
) (
  input  logic              CLK_48MHZ,
  input  logic              RESET,
  sdram_responder_if.slave  bus
);
  localparam int IDX_BITS = 2 + ROW_BITS + COL_BITS;
  localparam int DEPTH    = 1 << IDX_BITS;

  logic [15:0]         r_mem [DEPTH];
  logic [ROW_BITS-1:0] r_row [4];
  logic [3:0]          r_bank_open;
  logic                r_ready;
  logic                r_cl3;
  logic                r_err;
  logic [3:0]          r_err_code;
  logic [15:0]         r_refresh_count;

  cmd_e                w_cmd;
  logic [1:0]          w_ba;
  logic [IDX_BITS-1:0] w_idx;
  logic [15:0]         w_rd_data;
  logic                w_busy;
  logic [3:0]          w_bank_open_nxt;
  logic                w_ready_nxt;
  logic                w_cl3_nxt;
  logic                w_row_we;
  logic                w_mem_we;
  logic                w_rd_push;
  logic                w_refresh_inc;
  logic                w_err;
  logic [3:0]          w_err_code;
  logic                w_tm_err;
  logic [3:0]          w_tm_code;

  assign w_cmd = (bus.SDRAM_CKE & ~bus.SDRAM_CS)
               ? cmd_e'({bus.SDRAM_RAS, bus.SDRAM_CAS, bus.SDRAM_WE}) : CMD_NOP;
  assign w_ba  = bus.SDRAM_BA;
  assign w_idx = {w_ba, r_row[w_ba], bus.SDRAM_A[COL_BITS-1:0]};
  assign w_rd_data = {bus.SDRAM_DQMU ? 8'h00 : r_mem[w_idx][15:8],
                      bus.SDRAM_DQML ? 8'h00 : r_mem[w_idx][7:0]};

  // Command decode: next bank/mode state, array strobes and protocol errors.
  always_comb begin
    w_bank_open_nxt = r_bank_open;
    w_ready_nxt     = r_ready;
    w_cl3_nxt       = r_cl3;
    w_row_we        = 1'b0;
    w_mem_we        = 1'b0;
    w_rd_push       = 1'b0;
    w_refresh_inc   = 1'b0;
    w_err           = 1'b0;
    w_err_code      = ERR_NONE;
    case (w_cmd)
      CMD_LMR: begin
        if (mode_valid(bus.SDRAM_A)) begin
          w_ready_nxt = 1'b1;
          w_cl3_nxt   = (bus.SDRAM_A[6:4] == CL_3);
        end else begin
          w_err      = 1'b1;
          w_err_code = ERR_BAD_MODE;
        end
      end
      CMD_ACTIVE, CMD_READ, CMD_WRITE, CMD_PRECHARGE, CMD_REFRESH: begin
        if (!r_ready) begin
          w_err      = 1'b1;
          w_err_code = ERR_NOT_READY;
        end else if (w_cmd == CMD_ACTIVE) begin
          w_row_we              = 1'b1;
          w_bank_open_nxt[w_ba] = 1'b1;
          w_err                 = r_bank_open[w_ba];
          w_err_code            = r_bank_open[w_ba] ? ERR_BANK_OPEN : ERR_NONE;
        end else if (w_cmd == CMD_PRECHARGE) begin
          if (bus.SDRAM_A[10]) begin
            w_bank_open_nxt = 4'b0000;
          end else begin
            w_bank_open_nxt[w_ba] = 1'b0;
          end
        end else if (w_cmd == CMD_REFRESH) begin
          w_refresh_inc = ~(|r_bank_open);
          w_err         = |r_bank_open;
          w_err_code    = (|r_bank_open) ? ERR_REF_OPEN : ERR_NONE;
        end else if (!r_bank_open[w_ba]) begin
          w_err      = 1'b1;
          w_err_code = ERR_CLOSED_BANK;
        end else begin
          w_mem_we   = (w_cmd == CMD_WRITE);
          w_rd_push  = (w_cmd == CMD_READ);
          w_err      = (w_cmd == CMD_WRITE) && w_busy;
          w_err_code = ((w_cmd == CMD_WRITE) && w_busy) ? ERR_WR_COLLIDE : ERR_NONE;
          if (bus.SDRAM_A[10]) begin
            w_bank_open_nxt[w_ba] = 1'b0;
          end else begin
            w_bank_open_nxt[w_ba] = 1'b1;
          end
        end
      end
      default: begin
        w_err = 1'b0;
      end
    endcase
  end

`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
  logic [7:0] r_rcd_cnt [4];
  logic [7:0] r_rp_cnt  [4];
  logic [7:0] r_rfc_cnt;

  // Per-bank tRCD/tRP and global tRFC down-counters.
  always_ff @(posedge CLK_48MHZ) begin
    if (RESET) begin
      for (int b = 0; b < 4; b++) begin
        r_rcd_cnt[b] <= 8'd0;
        r_rp_cnt[b]  <= 8'd0;
      end
      r_rfc_cnt <= 8'd0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (w_row_we && (w_ba == 2'(b))) begin
          r_rcd_cnt[b] <= 8'(T_RCD - 1);
        end else if (r_rcd_cnt[b] != 8'd0) begin
          r_rcd_cnt[b] <= r_rcd_cnt[b] - 8'd1;
        end else begin
          r_rcd_cnt[b] <= 8'd0;
        end
        if (r_bank_open[b] && !w_bank_open_nxt[b]) begin
          r_rp_cnt[b] <= 8'(T_RP - 1);
        end else if (r_rp_cnt[b] != 8'd0) begin
          r_rp_cnt[b] <= r_rp_cnt[b] - 8'd1;
        end else begin
          r_rp_cnt[b] <= 8'd0;
        end
      end
      if (w_refresh_inc) begin
        r_rfc_cnt <= 8'(T_RFC - 1);
      end else if (r_rfc_cnt != 8'd0) begin
        r_rfc_cnt <= r_rfc_cnt - 8'd1;
      end else begin
        r_rfc_cnt <= 8'd0;
      end
    end
  end

  // Violating commands still execute; only the error is raised.
  always_comb begin
    w_tm_err  = 1'b0;
    w_tm_code = ERR_NONE;
    if (!r_ready || (w_cmd == CMD_NOP) || (w_cmd == CMD_BST)) begin
      w_tm_err = 1'b0;
    end else if (r_rfc_cnt != 8'd0) begin
      w_tm_err  = 1'b1;
      w_tm_code = ERR_TRFC;
    end else if ((w_cmd == CMD_ACTIVE) && (r_rp_cnt[w_ba] != 8'd0)) begin
      w_tm_err  = 1'b1;
      w_tm_code = ERR_TRP;
    end else if (((w_cmd == CMD_READ) || (w_cmd == CMD_WRITE)) && r_bank_open[w_ba]
                 && (r_rcd_cnt[w_ba] != 8'd0)) begin
      w_tm_err  = 1'b1;
      w_tm_code = ERR_TRCD;
    end else begin
      w_tm_err = 1'b0;
    end
  end
`else
  assign w_tm_err  = 1'b0;
  assign w_tm_code = ERR_NONE;
`endif

  // Control/status registers; first error since reset is the one kept.
  always_ff @(posedge CLK_48MHZ) begin
    if (RESET) begin
      for (int b = 0; b < 4; b++) begin
        r_row[b] <= {ROW_BITS{1'b0}};
      end
      r_bank_open     <= 4'b0000;
      r_ready         <= 1'b0;
      r_cl3           <= 1'b0;
      r_err           <= 1'b0;
      r_err_code      <= ERR_NONE;
      r_refresh_count <= 16'h0000;
    end else begin
      if (w_row_we) begin
        r_row[w_ba] <= bus.SDRAM_A[ROW_BITS-1:0];
      end
      r_bank_open     <= w_bank_open_nxt;
      r_ready         <= w_ready_nxt;
      r_cl3           <= w_cl3_nxt;
      r_refresh_count <= r_refresh_count + {15'd0, w_refresh_inc};
      if (!r_err && (w_err || w_tm_err)) begin
        r_err      <= 1'b1;
        r_err_code <= w_err ? w_err_code : w_tm_code;
      end
    end
  end

  // Backing array survives reset; each byte lane is written unless masked.
  always_ff @(posedge CLK_48MHZ) begin
    if (w_mem_we) begin
      if (!bus.SDRAM_DQML) r_mem[w_idx][7:0]  <= bus.D_IN[7:0];
      if (!bus.SDRAM_DQMU) r_mem[w_idx][15:8] <= bus.D_IN[15:8];
    end
  end

  sdram_cas_pipe u_cas_pipe (
    .i_clk   (CLK_48MHZ),
    .i_rst   (RESET),
    .i_cl3   (r_cl3),
    .i_push  (w_rd_push),
    .i_data  (w_rd_data),
    .o_data  (bus.D_OUT),
    .o_valid (bus.D_OE),
    .o_busy  (w_busy)
  );

  assign bus.READY         = r_ready;
  assign bus.BANK_OPEN     = r_bank_open;
  assign bus.ERR           = r_err;
  assign bus.ERR_CODE      = r_err_code;
  assign bus.REFRESH_COUNT = r_refresh_count;
endmodule

// File: tb/tb_sdram_responder.sv
// Scoreboard bench for sdram_responder: a bench-side memory/bank model
// predicts read data and arrival cycle; a negedge monitor pops and compares.
module tb_sdram_responder;
  localparam logic [2:0] C_LMR = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100, C_RD  = 3'b101, C_NOP = 3'b111;

  typedef struct { int due; logic [15:0] data; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t        q[$];
  logic [15:0] m_mem [int];
  logic        m_open [4];
  int          m_row [4];
  int          m_cl = 0;
  bit          m_ready = 1'b0;

  sdram_responder_if bus ();

  sdram_responder dut (.CLK_48MHZ(clk), .RESET(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer: every D_OE pulse must match the oldest prediction.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.D_OE === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_doe: D_OE=1 D_OUT=%h at cycle %0d, expected no read data", bus.D_OUT, cyc);
      end else begin
        e = q.pop_front();
        if (bus.D_OUT !== e.data || cyc != e.due) begin
          errors++;
          $display("FAIL read_data: got %h at cycle %0d, expected %h at cycle %0d", bus.D_OUT, cyc, e.data, e.due);
        end
      end
    end
  end

  task automatic set_nop();
    bus.SDRAM_CKE = 1'b1; bus.SDRAM_CS = 1'b1;
    {bus.SDRAM_RAS, bus.SDRAM_CAS, bus.SDRAM_WE} = C_NOP;
    bus.SDRAM_BA = 2'd0; bus.SDRAM_A = 13'd0; bus.D_IN = 16'h0000;
    bus.SDRAM_DQML = 1'b0; bus.SDRAM_DQMU = 1'b0;
  endtask

  // Drive one command for one clock and update the bench model.
  task automatic cmd(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a,
                     input logic [15:0] din, input logic dqml, input logic dqmu);
    int idx;
    logic [15:0] w;
    exp_t e;
    @(negedge clk);
    bus.SDRAM_CS = 1'b0; {bus.SDRAM_RAS, bus.SDRAM_CAS, bus.SDRAM_WE} = c;
    bus.SDRAM_BA = ba; bus.SDRAM_A = a; bus.D_IN = din;
    bus.SDRAM_DQML = dqml; bus.SDRAM_DQMU = dqmu;
    idx = int'(ba) * 256 + m_row[ba] * 16 + int'(a[3:0]);
    w = m_mem.exists(idx) ? m_mem[idx] : 16'h0000;
    if (c == C_LMR) begin
      if ((a[6:4] == 3'd2 || a[6:4] == 3'd3) && a[2:0] == 3'b000) begin
        m_ready = 1'b1; m_cl = int'(a[6:4]);
      end
    end else if (m_ready) begin
      if (c == C_ACT) begin
        m_open[ba] = 1'b1; m_row[ba] = int'(a[3:0]);
      end else if (c == C_PRE) begin
        if (a[10]) for (int b = 0; b < 4; b++) m_open[b] = 1'b0;
        else m_open[ba] = 1'b0;
      end else if ((c == C_RD || c == C_WR) && m_open[ba]) begin
        if (c == C_RD) begin
          e.due = cyc + 1 + m_cl;
          e.data = {dqmu ? 8'h00 : w[15:8], dqml ? 8'h00 : w[7:0]};
          q.push_back(e);
        end else begin
          m_mem[idx] = {dqmu ? w[15:8] : din[15:8], dqml ? w[7:0] : din[7:0]};
        end
        if (a[10]) m_open[ba] = 1'b0;
      end
    end
    @(posedge clk); #1;
    set_nop();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_nop(); rst = 1'b1;
    idle(2);
    q.delete();
    for (int b = 0; b < 4; b++) begin m_open[b] = 1'b0; m_row[b] = 0; end
    m_ready = 1'b0; m_cl = 0;
    rst = 1'b0;
  endtask

  // All predicted reads must have arrived within a fixed window.
  task automatic wait_drain();
    idle(6); #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d reads outstanding, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    do_reset(); #1;
    checks++; if (bus.D_OE !== 1'b0) begin errors++; $display("FAIL rst_doe: got %b expected 0", bus.D_OE); end
    checks++; if (bus.D_OUT !== 16'h0000) begin errors++; $display("FAIL rst_dout: got %h expected 0000", bus.D_OUT); end
    checks++; if (bus.READY !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", bus.READY); end
    checks++; if (bus.BANK_OPEN !== 4'b0000) begin errors++; $display("FAIL rst_bank: got %b expected 0000", bus.BANK_OPEN); end
    checks++; if ({bus.ERR, bus.ERR_CODE} !== 5'd0) begin errors++; $display("FAIL rst_err: got %b/%0d expected 0/0", bus.ERR, bus.ERR_CODE); end
    checks++; if (bus.REFRESH_COUNT !== 16'h0000) begin errors++; $display("FAIL rst_refcnt: got %h expected 0000", bus.REFRESH_COUNT); end
  endtask

  task automatic test_basic_cl2();
    cmd(C_LMR, 2'd0, 13'h020, 16'h0, 1'b0, 1'b0);
    checks++; if (bus.READY !== 1'b1) begin errors++; $display("FAIL lmr_ready: got %b expected 1", bus.READY); end
    cmd(C_ACT, 2'd1, 13'd3, 16'h0, 1'b0, 1'b0);
    checks++; if (bus.BANK_OPEN !== 4'b0010) begin errors++; $display("FAIL act_bank: got %b expected 0010", bus.BANK_OPEN); end
    idle(2);
    cmd(C_WR, 2'd1, 13'd5, 16'hA55A, 1'b0, 1'b0);
    cmd(C_RD, 2'd1, 13'd5, 16'h0, 1'b0, 1'b0);
    wait_drain();
    checks++; if ({bus.ERR, bus.ERR_CODE} !== 5'd0) begin errors++; $display("FAIL basic_err: got %b/%0d expected 0/0", bus.ERR, bus.ERR_CODE); end
  endtask

  task automatic test_cl3_mask();
    cmd(C_LMR, 2'd0, 13'h030, 16'h0, 1'b0, 1'b0);
    idle(1);
    cmd(C_WR, 2'd1, 13'd7, 16'hFFFF, 1'b0, 1'b0);
    cmd(C_WR, 2'd1, 13'd7, 16'h1234, 1'b0, 1'b1);
    cmd(C_RD, 2'd1, 13'd7, 16'h0, 1'b1, 1'b0);
    wait_drain();
    // Back-to-back reads: one word per cycle.
    cmd(C_RD, 2'd1, 13'd5, 16'h0, 1'b0, 1'b0);
    cmd(C_RD, 2'd1, 13'd7, 16'h0, 1'b0, 1'b0);
    cmd(C_RD, 2'd1, 13'd5, 16'h0, 1'b0, 1'b1);
    wait_drain();
    checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL cl3_err: got %b/%0d expected 0/0", bus.ERR, bus.ERR_CODE); end
  endtask

  task automatic test_closed_bank();
    do_reset();
    cmd(C_LMR, 2'd0, 13'h020, 16'h0, 1'b0, 1'b0);
    cmd(C_RD, 2'd2, 13'd1, 16'h0, 1'b0, 1'b0);
    checks++; if ({bus.ERR, bus.ERR_CODE} !== {1'b1, 4'd1}) begin errors++; $display("FAIL closed_err: got %b/%0d expected 1/1", bus.ERR, bus.ERR_CODE); end
    idle(5);
    cmd(C_ACT, 2'd0, 13'd2, 16'h0, 1'b0, 1'b0);
    idle(2);
    cmd(C_ACT, 2'd0, 13'd4, 16'h0, 1'b0, 1'b0);
    checks++; if ({bus.ERR, bus.ERR_CODE} !== {1'b1, 4'd1}) begin errors++; $display("FAIL first_err_kept: got %b/%0d expected 1/1", bus.ERR, bus.ERR_CODE); end
    checks++; if (bus.BANK_OPEN !== 4'b0001) begin errors++; $display("FAIL reopen_bank: got %b expected 0001", bus.BANK_OPEN); end
  endtask

  task automatic test_mode_errors();
    do_reset();
    cmd(C_ACT, 2'd0, 13'd1, 16'h0, 1'b0, 1'b0);
    checks++; if (bus.ERR_CODE !== 4'd4 || bus.BANK_OPEN !== 4'b0000) begin errors++; $display("FAIL not_ready: got code %0d bank %b expected 4/0000", bus.ERR_CODE, bus.BANK_OPEN); end
    do_reset();
    cmd(C_LMR, 2'd0, 13'h050, 16'h0, 1'b0, 1'b0);
    checks++; if (bus.ERR_CODE !== 4'd5 || bus.READY !== 1'b0) begin errors++; $display("FAIL bad_cl: got code %0d ready %b expected 5/0", bus.ERR_CODE, bus.READY); end
    cmd(C_LMR, 2'd0, 13'h021, 16'h0, 1'b0, 1'b0);
    checks++; if (bus.READY !== 1'b0) begin errors++; $display("FAIL bad_bl: got ready %b expected 0", bus.READY); end
    cmd(C_LMR, 2'd0, 13'h020, 16'h0, 1'b0, 1'b0);
    checks++; if (bus.READY !== 1'b1 || bus.ERR_CODE !== 4'd5) begin errors++; $display("FAIL good_lmr: got ready %b code %0d expected 1/5", bus.READY, bus.ERR_CODE); end
  endtask

  task automatic test_refresh();
    do_reset();
    cmd(C_LMR, 2'd0, 13'h020, 16'h0, 1'b0, 1'b0);
    cmd(C_ACT, 2'd0, 13'd0, 16'h0, 1'b0, 1'b0);
    idle(2);
    cmd(C_REF, 2'd0, 13'd0, 16'h0, 1'b0, 1'b0);
    checks++; if (bus.ERR_CODE !== 4'd3 || bus.REFRESH_COUNT !== 16'h0000) begin errors++; $display("FAIL ref_open: got code %0d count %h expected 3/0000", bus.ERR_CODE, bus.REFRESH_COUNT); end
    do_reset();
    cmd(C_LMR, 2'd0, 13'h020, 16'h0, 1'b0, 1'b0);
    idle(4);
    @(negedge clk);
    bus.SDRAM_CS = 1'b0; {bus.SDRAM_RAS, bus.SDRAM_CAS, bus.SDRAM_WE} = C_REF;
    repeat (65535) @(posedge clk);
    #1;
    checks++; if (bus.REFRESH_COUNT !== 16'hFFFF) begin errors++; $display("FAIL ref_max: got %h expected ffff", bus.REFRESH_COUNT); end
    @(posedge clk); #1;
    set_nop();
    checks++; if (bus.REFRESH_COUNT !== 16'h0000) begin errors++; $display("FAIL ref_wrap: got %h expected 0000", bus.REFRESH_COUNT); end
  endtask

  task automatic test_autoprecharge();
    do_reset();
    cmd(C_LMR, 2'd0, 13'h020, 16'h0, 1'b0, 1'b0);
    cmd(C_ACT, 2'd2, 13'd1, 16'h0, 1'b0, 1'b0);
    idle(2);
    cmd(C_WR, 2'd2, 13'h0402, 16'h5A5A, 1'b0, 1'b0);
    checks++; if (bus.BANK_OPEN !== 4'b0000) begin errors++; $display("FAIL ap_close: got %b expected 0000", bus.BANK_OPEN); end
    cmd(C_RD, 2'd2, 13'd2, 16'h0, 1'b0, 1'b0);
    idle(4);
    checks++; if (bus.ERR_CODE !== 4'd1) begin errors++; $display("FAIL ap_read: got code %0d expected 1", bus.ERR_CODE); end
    cmd(C_ACT, 2'd0, 13'd2, 16'h0, 1'b0, 1'b0);
    cmd(C_ACT, 2'd3, 13'd4, 16'h0, 1'b0, 1'b0);
    checks++; if (bus.BANK_OPEN !== 4'b1001) begin errors++; $display("FAIL two_open: got %b expected 1001", bus.BANK_OPEN); end
    idle(2);
    cmd(C_PRE, 2'd1, 13'h0400, 16'h0, 1'b0, 1'b0);
    checks++; if (bus.BANK_OPEN !== 4'b0000) begin errors++; $display("FAIL pre_all: got %b expected 0000", bus.BANK_OPEN); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cmd(C_LMR, 2'd0, 13'h030, 16'h0, 1'b0, 1'b0);
    cmd(C_ACT, 2'd3, 13'd5, 16'h0, 1'b0, 1'b0);
    idle(2);
    for (int i = 0; i < 3; i++) cmd(C_WR, 2'd3, 13'(i), 16'h1111 * 16'(i + 1), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cmd(C_RD, 2'd3, 13'(i), 16'h0, 1'b0, 1'b0);
    cmd(C_WR, 2'd3, 13'd0, 16'hAAAA, 1'b0, 1'b0);
    checks++; if (bus.ERR_CODE !== 4'd9) begin errors++; $display("FAIL collide: got code %0d expected 9", bus.ERR_CODE); end
    wait_drain();
    cmd(C_RD, 2'd3, 13'd0, 16'h0, 1'b0, 1'b0);
    wait_drain();
  endtask

  task automatic test_reset_mid_read();
    cmd(C_RD, 2'd3, 13'd1, 16'h0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.D_OE !== 1'b0 || bus.READY !== 1'b0) begin errors++; $display("FAIL mid_rst: got doe %b ready %b expected 0/0", bus.D_OE, bus.READY); end
    q.delete();
    for (int b = 0; b < 4; b++) m_open[b] = 1'b0;
    m_ready = 1'b0;
    idle(1);
    rst = 1'b0;
    idle(5);
  endtask

`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
  task automatic test_timing();
    do_reset();
    cmd(C_LMR, 2'd0, 13'h020, 16'h0, 1'b0, 1'b0);
    cmd(C_ACT, 2'd1, 13'd3, 16'h0, 1'b0, 1'b0);
    cmd(C_RD, 2'd1, 13'd5, 16'h0, 1'b0, 1'b0);
    wait_drain();
    checks++; if (bus.ERR_CODE !== 4'd6) begin errors++; $display("FAIL trcd: got code %0d expected 6", bus.ERR_CODE); end
  endtask
`endif

  initial begin
    set_nop();
    test_reset();
    test_basic_cl2();
    test_cl3_mask();
    test_closed_bank();
    test_mode_errors();
    test_refresh();
    test_autoprecharge();
    test_back_to_back();
    test_reset_mid_read();
`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
    test_timing();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
